// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding,
// accumulate-op codes and a wide zero constant.
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StFix  = 2'd2,
        StEnd  = 2'd3
    } mul_state_e;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_MADD = 2'b01;
    localparam logic [1:0] ACC_MSUB = 2'b10;

    // Wide enough for any supported 2*WIDTH result; users slice the low bits.
    localparam int unsigned MAX_DWORD_BITS = 256;
    localparam logic [MAX_DWORD_BITS-1:0] ZERO_DWORD = '0;

endpackage

// File: rtl/mul_pp_sum.sv
// Combinational partial-product adder: sums RADIX_BITS shifted copies of the
// multiplicand selected by the low multiplier bits.
module mul_pp_sum #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 2
) (
    input  logic [2*WIDTH-1:0]    mcand,
    input  logic [RADIX_BITS-1:0] mplier_bits,
    output logic [2*WIDTH-1:0]    pp_sum
);

    always_comb begin
        pp_sum = '0;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (mplier_bits[j]) begin
                pp_sum = pp_sum + (mcand << j);
            end
        end
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier with madd/msub, retiring RADIX_BITS bits per cycle.
// Optional MUL_EARLY_EXIT_EN: leave the ON loop once the remaining multiplier bits are zero.
module mul_iter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 signed_mul_i,
    input  logic [1:0]           acc_op_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int unsigned N  = WIDTH / RADIX_BITS;
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(N);
    localparam logic [DW-1:0] ZERO = ZERO_DWORD[DW-1:0];

    if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
        $error("mul_iter: RADIX_BITS must divide WIDTH");
    end

    mul_state_e      state_q;
    logic [DW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [DW-1:0]   prod_q;
    logic [DW-1:0]   acc_q;
    logic [1:0]      acc_op_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;

    logic            sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [DW-1:0]   pp_sum;
    logic [DW-1:0]   prod_signed;
    logic [DW-1:0]   fix_value;
    logic            on_done;

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned value.
    always_comb begin
        sign1 = signed_mul_i & opdata1_i[WIDTH-1];
        sign2 = signed_mul_i & opdata2_i[WIDTH-1];
        mag1  = sign1 ? -opdata1_i : opdata1_i;
        mag2  = sign2 ? -opdata2_i : opdata2_i;
    end

    always_comb begin
        prod_signed = neg_q ? -prod_q : prod_q;
        unique case (acc_op_q)
            ACC_MADD: fix_value = acc_q + prod_signed;
            ACC_MSUB: fix_value = acc_q - prod_signed;
            default:  fix_value = prod_signed;
        endcase
    end

`ifdef MUL_EARLY_EXIT_EN
    assign on_done = (cnt_q == CNT_DONE) || (mplier_q == '0);
`else
    assign on_done = (cnt_q == CNT_DONE);
`endif

    mul_pp_sum #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_pp_sum (
        .mcand       (mcand_q),
        .mplier_bits (mplier_q[RADIX_BITS-1:0]),
        .pp_sum      (pp_sum)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            result_o <= ZERO;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_o  <= 1'b0;
                    result_o <= ZERO;
                    if (start_i && !annul_i) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag1};
                        mplier_q <= mag2;
                        neg_q    <= sign1 ^ sign2;
                        acc_q    <= acc_i;
                        acc_op_q <= acc_op_i;
                        prod_q   <= ZERO;
                        cnt_q    <= '0;
                        busy_o   <= 1'b1;
                        state_q  <= StOn;
                    end
                end
                StOn: begin
                    if (annul_i) begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end else if (on_done) begin
                        state_q <= StFix;
                    end else begin
                        prod_q   <= prod_q + pp_sum;
                        mcand_q  <= mcand_q << RADIX_BITS;
                        mplier_q <= mplier_q >> RADIX_BITS;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                StFix: begin
                    busy_o <= 1'b0;
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else begin
                        prod_q  <= fix_value;
                        state_q <= StEnd;
                    end
                end
                StEnd: begin
                    // Result is held for as long as the caller keeps start_i high.
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= ZERO;
                        state_q  <= StIdle;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= prod_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter (WIDTH=32, RADIX_BITS=2).
module tb_mul_iter;

    logic        clk;
    logic        resetn;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        signed_mul;
    logic [1:0]  acc_op;
    logic [63:0] acc;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int errors;
    int checks;

    mul_iter #(
        .WIDTH      (32),
        .RADIX_BITS (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .signed_mul_i (signed_mul),
        .acc_op_i     (acc_op),
        .acc_i        (acc),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected cycles from the start edge to ready.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int iters;
        m = (s && b[31]) ? -b : b;
        iters = 0;
        for (int i = 0; i < 16; i++) begin
            if ((m >> (2 * i)) != 0) iters = i + 1;
        end
`ifndef MUL_EARLY_EXIT_EN
        iters = 16;
`endif
        return iters + 3;
    endfunction

    // Issues one operation and leaves start high; lat = 0 if ready never rises.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [1:0] op, input logic [63:0] ac,
                         output logic [63:0] res, output int lat);
        opdata1 = a; opdata2 = b; signed_mul = s; acc_op = op; acc = ac; start = 1'b1;
        @(posedge clk);
        #1;
        // Operands must have been captured at the start edge.
        opdata1 = 32'h5A5A_1234; opdata2 = 32'hDEAD_BEEF; acc = 64'h0123_4567_89AB_CDEF;
        signed_mul = ~s; acc_op = 2'b01;
        lat = 0;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; annul = 1'b0;
        opdata1 = '0; opdata2 = '0; signed_mul = 1'b0; acc_op = 2'b00; acc = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned_max();
        int lat;
        logic busy_e1;
        lat = 0;
        busy_e1 = 1'b0;
        opdata1 = 32'hFFFF_FFFF; opdata2 = 32'hFFFF_FFFF; signed_mul = 1'b0;
        acc_op = 2'b00; acc = 64'h0; start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) busy_e1 = busy;
            if (ready) begin
                lat = k;
                break;
            end
        end
        checks++; if (busy_e1 !== 1'b1) begin errors++; $display("FAIL umax_busy_e1 got %b exp 1", busy_e1); end
        checks++; if (lat != 19) begin errors++; $display("FAIL umax_latency got %0d exp 19", lat); end
        checks++; if (result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL umax_result got %h exp fffffffe00000001", result);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL umax_hold_ready got %b exp 1", ready); end
        checks++; if (result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL umax_hold_result got %h exp fffffffe00000001", result);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL umax_end_busy got %b exp 0", busy); end
        release_start();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL umax_drop_ready got %b exp 0", ready); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL umax_drop_result got %h exp 0", result); end
    endtask

    task automatic test_vectors(input string tag, input logic [31:0] a[5], input logic [31:0] b[5],
                                input logic s[5], input logic [1:0] op[5], input logic [63:0] ac[5],
                                input logic [63:0] exp[5]);
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(a[i], b[i], s[i], op[i], ac[i], res, lat);
            checks++; if (res !== exp[i]) begin
                errors++; $display("FAIL %s_%0d_result got %h exp %h", tag, i, res, exp[i]);
            end
            checks++; if (lat != exp_lat(b[i], s[i])) begin
                errors++; $display("FAIL %s_%0d_latency got %0d exp %0d", tag, i, lat, exp_lat(b[i], s[i]));
            end
            release_start();
            checks++; if (ready !== 1'b0) begin
                errors++; $display("FAIL %s_%0d_drop got %b exp 0", tag, i, ready);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] a[5]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        logic [31:0] b[5]  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'd7};
        logic        s[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  op[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [63:0] ac[5] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        logic [63:0] ex[5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                               64'h4000_0000_0000_0000, 64'h0000_0000_0000_000A,
                               64'h0000_0006_FFFF_FFEB};
        test_vectors("signed", a, b, s, op, ac, ex);
    endtask

    task automatic test_accumulate();
        logic [31:0] a[5]  = '{32'd2, 32'd1, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] b[5]  = '{32'd3, 32'd1, 32'd4, 32'd4, 32'hFFFF_FFFF};
        logic        s[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  op[5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
        logic [63:0] ac[5] = '{64'h0000_0001_0000_0000, 64'h0, 64'd100, 64'h55, 64'd5};
        logic [63:0] ex[5] = '{64'h0000_0001_0000_0006, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h70, 64'hC, 64'd6};
        test_vectors("acc", a, b, s, op, ac, ex);
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        opdata1 = 32'hFFFF_FFFF; opdata2 = 32'hFFFF_FFFF; signed_mul = 1'b0;
        acc_op = 2'b00; acc = 64'h0; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_busy got %b exp 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_ready got %b exp 0", ready); end
        // Immediate restart: an early ready would reveal the cancelled op completing.
        do_op(32'd6, 32'd7, 1'b0, 2'b00, 64'h0, res, lat);
        checks++; if (res !== 64'h2A) begin errors++; $display("FAIL annul_restart_result got %h exp 2a", res); end
        checks++; if (lat != exp_lat(32'd7, 1'b0)) begin
            errors++; $display("FAIL annul_restart_latency got %0d exp %0d", lat, exp_lat(32'd7, 1'b0));
        end
        release_start();
        start = 1'b1; annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_idle_busy got %b exp 0", busy); end
        start = 1'b0; annul = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        opdata1 = 32'hFFFF_FFFF; opdata2 = 32'hFFFF_FFFF; signed_mul = 1'b0;
        acc_op = 2'b00; acc = 64'h0; start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_on_busy_pre got %b exp 1", busy); end
        resetn = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_on_busy got %b exp 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_on_ready got %b exp 0", ready); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_op(32'd5, 32'd5, 1'b0, 2'b00, 64'h0, res, lat);
        checks++; if (res !== 64'h19) begin errors++; $display("FAIL rst_after_result got %h exp 19", res); end
        checks++; if (lat != exp_lat(32'd5, 1'b0)) begin
            errors++; $display("FAIL rst_after_latency got %0d exp %0d", lat, exp_lat(32'd5, 1'b0));
        end
        // Reset while holding a valid result.
        resetn = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_end_ready got %b exp 0", ready); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL rst_end_result got %h exp 0", result); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_early_exit();
        logic [63:0] res;
        int lat;
        int lat_zero, lat_one;
`ifdef MUL_EARLY_EXIT_EN
        lat_zero = 3;
        lat_one  = 4;
`else
        lat_zero = 19;
        lat_one  = 19;
`endif
        do_op(32'h1234, 32'h0, 1'b0, 2'b00, 64'h0, res, lat);
        checks++; if (res !== 64'h0) begin errors++; $display("FAIL ee_zero_result got %h exp 0", res); end
        checks++; if (lat != lat_zero) begin
            errors++; $display("FAIL ee_zero_latency got %0d exp %0d", lat, lat_zero);
        end
        release_start();
        do_op(32'h1234, 32'h1, 1'b0, 2'b00, 64'h0, res, lat);
        checks++; if (res !== 64'h1234) begin errors++; $display("FAIL ee_one_result got %h exp 1234", res); end
        checks++; if (lat != lat_one) begin
            errors++; $display("FAIL ee_one_latency got %0d exp %0d", lat, lat_one);
        end
        release_start();
        do_op(32'h1, 32'hFFFF_FFFF, 1'b0, 2'b00, 64'h0, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF) begin
            errors++; $display("FAIL ee_full_result got %h exp ffffffff", res);
        end
        checks++; if (lat != 19) begin errors++; $display("FAIL ee_full_latency got %0d exp 19", lat); end
        release_start();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_accumulate();
        test_annul();
        test_reset_mid();
        test_early_exit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative shift-add multiplier with multiply-accumulate modes, for the execute stage's multi-cycle unit. Retires RADIX_BITS multiplier bits per cycle. Handles signed or unsigned operands, plain multiply, multiply-add and multiply-subtract against a caller-supplied 2·WIDTH accumulator. Supports cancellation mid-operation. Uses the same start/ready level handshake as the existing divider and multiplier units, so it drops into the same pipeline stall logic.

## Interface
- WIDTH, 32: operand width; result is 2·WIDTH.
- RADIX_BITS, 2: multiplier bits consumed per cycle; must divide WIDTH (elaboration error otherwise). N = WIDTH/RADIX_BITS.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- opdata1_i  in  WIDTH  multiplicand.
- opdata2_i  in  WIDTH  multiplier.
- signed_mul_i  in  1  1 = two's-complement operands.
- acc_op_i  in  2  00 plain, 01 madd (acc + p), 10 msub (acc − p), 11 treated as plain.
- acc_i  in  2·WIDTH  accumulator operand.
- start_i  in  1  request; held high by the caller until ready_o is seen.
- annul_i  in  1  cancel the current operation.
- result_o  out  2·WIDTH  result. Reset value 0.
- ready_o  out  1  result valid. Reset value 0.
- busy_o  out  1  high in states ON and FIX. Reset value 0.

## Operation
- States: IDLE, ON, FIX, END.
- **IDLE**
  - If start_i & !annul_i: capture the operands.
    - mcand ← |opdata1_i|, zero-extended to 2·WIDTH.
    - mplier ← |opdata2_i|. Magnitude is taken only when signed_mul_i and the sign bit are both 1.
    - Also capture neg = signed_mul_i & (sign1 ^ sign2), acc_i, acc_op_i and signed_mul_i.
    - Clear prod and cnt; go to ON.
  - Otherwise: ready_o ← 0, result_o ← 0.
- **ON**, each cycle:
  - If annul_i: go to IDLE. prod is discarded and no outputs change.
  - Else if cnt == N: go to FIX.
  - Else:
    - prod += Σ_{j<RADIX_BITS} mplier[j] ? (mcand << j) : 0.
    - mcand <<= RADIX_BITS; mplier >>= RADIX_BITS; cnt++.
- **FIX**
  - If annul_i: go to IDLE.
  - Else:
    - p = neg ? −prod : prod.
    - prod ← p, acc + p or acc − p according to the captured op, all mod 2^(2·WIDTH).
    - Go to END.
- **END**
  - result_o ← prod, ready_o ← 1.
  - If start_i == 0 in the same cycle: ready_o ← 0, result_o ← 0, go to IDLE.
  - annul_i is ignored in END.
- Arithmetic and boundary rules:
  - The magnitude of the most negative input (2^(WIDTH−1)) fits unsigned in WIDTH bits; no special case is needed.
  - Inputs are captured once. Changes to opdata*/acc* after the start edge have no effect.
  - annul_i and start_i high together in IDLE: the operation does not start.
- Reset in any state: go to IDLE; result_o, ready_o, busy_o ← 0; internal registers don't-care.

## Timing
- E0 is the edge that samples start_i in IDLE.
- ON iterations occur on E1..EN; E(N+1) moves ON→FIX; E(N+2) executes FIX and moves to END.
- ready_o and result_o are registered on E(N+3), which is **latency N+3**.
  - WIDTH=32, RADIX_BITS=2: 19 cycles.
  - RADIX_BITS=1: 35 cycles.
- ready_o stays high while start_i stays high.
- The earliest restart is the cycle after ready_o falls.
- busy_o is high from E1 through E(N+2).

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - In ON, if mplier == 0 (remaining bits zero), go to FIX immediately without an add.
  - Latency becomes variable, with minimum 3 (opdata2 magnitude 0: E1→FIX, E2→END, E3 ready).
  - Results are identical.
- Undefined: latency is always N+3.

## Structure
- Shared package mul_pkg:
  - state encoding (IDLE, ON, FIX, END);
  - acc_op encoding constants (ACC_NONE, ACC_MADD, ACC_MSUB);
  - a ZERO_DWORD constant.
- Sub-module mul_pp_sum: combinational RADIX_BITS-term partial-product adder (mcand, mplier low bits → 2·WIDTH sum). Instantiated once.
- The cnt register is $clog2(N+1) bits wide.

## Test plan
All cases use WIDTH=32, RADIX_BITS=2, macro off unless stated.
1. Unsigned 0xFFFFFFFF × 0xFFFFFFFF, plain → result 0xFFFFFFFE00000001, ready exactly 19 cycles after E0. ready stays high while start is held; ready and result return to 0 the cycle after start falls.
2. Signed −3 (0xFFFFFFFD) × 7 → 0xFFFFFFFFFFFFFFEB. Signed 0x80000000 × 0x80000000 → 0x4000000000000000. Same operands unsigned → 0x4000000000000000.
3. madd, acc 0x0000000100000000, signed 2 × 3 → 0x0000000100000006. msub, acc 0, 1 × 1 → 0xFFFFFFFFFFFFFFFF.
4. annul_i pulsed at cycle 5 of ON → busy drops next cycle and ready never rises. An immediate restart with 6 × 7 → 0x2A after a full latency.
5. resetn asserted mid-ON → outputs 0, state IDLE. A subsequent 5 × 5 → 0x19.
6. MUL_EARLY_EXIT_EN: 0x1234 × 0 → 0, ready 3 cycles after E0. 0x1234 × 1 → 0x1234 in 4 cycles. 1 × 0xFFFFFFFF unsigned → 0xFFFFFFFF in 19 cycles.
